nand_prog_seq: RTL and testbench

//  Page-program sequencer driving the mem_command SPI NAND command controller from upstream.
//  A single i_Start issues the full chain WRITE_ENABLE -> PROG_LOAD1 -> PROG_EXEC -> GET_FEATURE(C0) polling.
//  The chain ends when the device is no longer busy, or when the poll count hits its limit.

---
 rtl/command_vars.sv | 43 ++++
 rtl/nand_prog_seq_issuer.sv | 76 +++++++
 rtl/nand_prog_seq.sv | 208 ++++++++++++++++++++
 tb/tb_nand_prog_seq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/command_vars.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | command_vars: SPI NAND command set, status bits and address packing  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package command_vars;

    typedef enum logic [3:0] {
        WRITE_ENABLE  = 4'd0,
        WRITE_DISABLE = 4'd1,
        GET_FEATURE   = 4'd2,
        SET_FEATURE   = 4'd3,
        PAGE_READ     = 4'd4,
        READ_CACHE    = 4'd5,
        PROG_LOAD1    = 4'd6,
        PROG_EXEC     = 4'd7,
        BLOCK_ERASE   = 4'd8,
        RESET_DEVICE  = 4'd9
    } SPI_Command;

    localparam int ST_BUSY  = 0;
    localparam int ST_PFAIL = 3;

    // Bits not used by a given command stay zero.
    function automatic logic [23:0] pack_addr(
        input SPI_Command  cmd,
        input logic [12:0] col,
        input logic [15:0] page,
        input logic [7:0]  feat
    );
        logic [23:0] a;
        a = 24'h0;
        case (cmd)
            PROG_LOAD1:  a[12:0] = col;
            PROG_EXEC:   a[15:0] = page;
            GET_FEATURE: a[15:8] = feat;
            default:     a = 24'h0;
        endcase
        return a;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nand_prog_seq_issuer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nand_cmd_issuer: one-shot DV issue to mem_command, completion on the |
// | ready low-then-high return.               Revision: 1.0              |
// +----------------------------------------------------------------------+
module nand_cmd_issuer
    import command_vars::*;
(
    input  logic        CLK1,
    input  logic        rst_n,
    input  logic        i_Req,
    input  SPI_Command  i_Cmd,
    input  logic [23:0] i_Addr,
    input  logic        i_CM_Ready,
    output SPI_Command  o_Command,
    output logic        o_CM_DV,
    output logic [23:0] o_Addr_Data,
    output logic        o_Issued,
    output logic        o_Complete
);

    logic        pending_q, pending_d;
    logic        seen_low_q, seen_low_d;
    logic        dv_q, dv_d;
    SPI_Command  cmd_q, cmd_d;
    logic [23:0] addr_q, addr_d;
    logic        w_issue;
    logic        w_complete;

    always_comb begin
        w_issue    = i_Req && i_CM_Ready && !pending_q;
        w_complete = pending_q && seen_low_q && i_CM_Ready;
        pending_d  = pending_q;
        seen_low_d = seen_low_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        dv_d       = w_issue;
        if (w_issue) begin
            pending_d  = 1'b1;
            seen_low_d = 1'b0;
            cmd_d      = i_Cmd;
            addr_d     = i_Addr;
        end else if (pending_q) begin
            if (!i_CM_Ready) begin
                seen_low_d = 1'b1;
            end
            if (w_complete) begin
                pending_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK1 or negedge rst_n) begin
        if (!rst_n) begin
            pending_q  <= 1'b0;
            seen_low_q <= 1'b0;
            dv_q       <= 1'b0;
            cmd_q      <= WRITE_ENABLE;
            addr_q     <= 24'h0;
        end else begin
            pending_q  <= pending_d;
            seen_low_q <= seen_low_d;
            dv_q       <= dv_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
        end
    end

    assign o_Command   = cmd_q;
    assign o_CM_DV     = dv_q;
    assign o_Addr_Data = addr_q;
    assign o_Issued    = w_issue;
    assign o_Complete  = w_complete;

endmodule
`default_nettype wire

// File: rtl/nand_prog_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nand_prog_seq: WREN -> PROG_LOAD1 -> PROG_EXEC -> status poll chain  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module nand_prog_seq
    import command_vars::*;
#(
    parameter int         MIN_LOAD_BYTES = 128,
    parameter int         MAX_POLLS      = 1024,
    parameter int         POLL_GAP       = 16,
    parameter logic [7:0] STATUS_ADDR    = 8'hC0
) (
    input  logic        CLK1,
    input  logic        rst_n,
    input  logic        i_Start,
    input  logic [12:0] i_Col_Addr,
    input  logic [15:0] i_Page_Addr,
    input  logic [11:0] i_Fifo_Count,
    output logic        o_Busy,
    output logic        o_Done,
    output logic        o_Reject,
    output logic        o_Fail,
    output logic        o_Timeout,
    output logic [7:0]  o_Status,
    output SPI_Command  o_Command,
    output logic        o_CM_DV,
    output logic [23:0] o_Addr_Data,
    input  logic        i_CM_Ready,
    input  logic [7:0]  i_RX_Feature_Byte,
    input  logic        i_RX_Feature_DV
);

    localparam int PCW = $clog2(MAX_POLLS + 1);
    localparam int GCW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [PCW-1:0] c_MAX_POLLS = PCW'(MAX_POLLS);
    localparam logic [GCW-1:0] c_GAP_LAST  = GCW'(POLL_GAP - 1);
    localparam logic [11:0]    c_MIN_LOAD  = 12'(MIN_LOAD_BYTES);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WREN  = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_EXEC  = 3'd3;
    localparam logic [2:0] c_ST_POLL  = 3'd4;
    localparam logic [2:0] c_ST_PWAIT = 3'd5;
    localparam logic [2:0] c_ST_GAP   = 3'd6;
    localparam logic [2:0] c_ST_FIN   = 3'd7;

    logic [2:0]     state_q, state_d;
    logic [12:0]    col_q, col_d;
    logic [15:0]    page_q, page_d;
    logic [PCW-1:0] poll_cnt_q, poll_cnt_d;
    logic [GCW-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]     status_q, status_d;
    logic           rx_seen_q, rx_seen_d;
    logic           fail_q, fail_d;
    logic           timeout_q, timeout_d;
    logic           reject_q, reject_d;

    logic           w_req;
    SPI_Command     w_cmd;
    logic [23:0]    w_addr;
    logic           w_issued;
    logic           w_complete;
    logic [7:0]     w_eff_status;

    nand_cmd_issuer u_issuer (
        .CLK1        (CLK1),
        .rst_n       (rst_n),
        .i_Req       (w_req),
        .i_Cmd       (w_cmd),
        .i_Addr      (w_addr),
        .i_CM_Ready  (i_CM_Ready),
        .o_Command   (o_Command),
        .o_CM_DV     (o_CM_DV),
        .o_Addr_Data (o_Addr_Data),
        .o_Issued    (w_issued),
        .o_Complete  (w_complete)
    );

    always_ff @(posedge CLK1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= c_ST_IDLE;
            col_q      <= 13'h0;
            page_q     <= 16'h0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            status_q   <= 8'h0;
            rx_seen_q  <= 1'b0;
            fail_q     <= 1'b0;
            timeout_q  <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            page_q     <= page_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            status_q   <= status_d;
            rx_seen_q  <= rx_seen_d;
            fail_q     <= fail_d;
            timeout_q  <= timeout_d;
            reject_q   <= reject_d;
        end
    end

    // A byte arriving with the ready rise is used in the same cycle; no byte at all reads as busy.
    always_comb begin
        if (i_RX_Feature_DV) begin
            w_eff_status = i_RX_Feature_Byte;
        end else if (rx_seen_q) begin
            w_eff_status = status_q;
        end else begin
            w_eff_status = 8'h01;
        end
    end

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        page_d     = page_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        status_d   = status_q;
        rx_seen_d  = rx_seen_q;
        fail_d     = fail_q;
        timeout_d  = timeout_q;
        reject_d   = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (i_Start) begin
                    if (i_Fifo_Count >= c_MIN_LOAD) begin
                        col_d      = i_Col_Addr;
                        page_d     = i_Page_Addr;
                        poll_cnt_d = '0;
                        status_d   = 8'h0;
                        fail_d     = 1'b0;
                        timeout_d  = 1'b0;
                        state_d    = c_ST_WREN;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            c_ST_WREN: if (w_complete) state_d = c_ST_LOAD;
            c_ST_LOAD: if (w_complete) state_d = c_ST_EXEC;
            c_ST_EXEC: if (w_complete) state_d = c_ST_POLL;
            c_ST_POLL: begin
                if (w_issued) begin
                    if (poll_cnt_q != c_MAX_POLLS) begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
                    rx_seen_d = 1'b0;
                    state_d   = c_ST_PWAIT;
                end
            end
            c_ST_PWAIT: begin
                if (i_RX_Feature_DV) begin
                    status_d  = i_RX_Feature_Byte;
                    rx_seen_d = 1'b1;
                end
                if (w_complete) begin
                    if (!w_eff_status[ST_BUSY]) begin
                        fail_d  = w_eff_status[ST_PFAIL];
                        state_d = c_ST_FIN;
                    end else if (poll_cnt_q == c_MAX_POLLS) begin
                        timeout_d = 1'b1;
                        state_d   = c_ST_FIN;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = c_ST_GAP;
                    end
                end
            end
            c_ST_GAP: begin
                if (gap_cnt_q == c_GAP_LAST) begin
                    state_d = c_ST_POLL;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            c_ST_FIN: state_d = c_ST_IDLE;
            default:  state_d = c_ST_IDLE;
        endcase
    end

    always_comb begin
        o_Busy = (state_q != c_ST_IDLE) && (state_q != c_ST_FIN);
        o_Done = (state_q == c_ST_FIN);
        w_req  = 1'b0;
        w_cmd  = WRITE_ENABLE;
        case (state_q)
            c_ST_WREN: begin w_req = 1'b1; w_cmd = WRITE_ENABLE; end
            c_ST_LOAD: begin w_req = 1'b1; w_cmd = PROG_LOAD1;   end
            c_ST_EXEC: begin w_req = 1'b1; w_cmd = PROG_EXEC;    end
            c_ST_POLL: begin w_req = 1'b1; w_cmd = GET_FEATURE;  end
            default:   begin w_req = 1'b0; w_cmd = WRITE_ENABLE; end
        endcase
        w_addr = pack_addr(w_cmd, col_q, page_q, STATUS_ADDR);
    end

    assign o_Reject  = reject_q;
    assign o_Fail    = fail_q;
    assign o_Timeout = timeout_q;
    assign o_Status  = status_q;

endmodule
`default_nettype wire

// File: tb/tb_nand_prog_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nand_prog_seq: directed bench with a mem_command responder and a  |
// | sequence-level model.                     Revision: 1.0              |
// +----------------------------------------------------------------------+
module tb_nand_prog_seq;
    import command_vars::*;

    localparam int TB_MAX_POLLS = 4;
    localparam int TB_POLL_GAP  = 16;

    typedef struct packed {
        SPI_Command  cmd;
        logic [23:0] addr;
    } ent_t;

    logic        CLK1 = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_Start = 1'b0;
    logic [12:0] i_Col_Addr = 13'h0;
    logic [15:0] i_Page_Addr = 16'h0;
    logic [11:0] i_Fifo_Count = 12'h0;
    logic        i_CM_Ready = 1'b1;
    logic [7:0]  i_RX_Feature_Byte = 8'h0;
    logic        i_RX_Feature_DV = 1'b0;
    logic        o_Busy, o_Done, o_Reject, o_Fail, o_Timeout, o_CM_DV;
    logic [7:0]  o_Status;
    logic [23:0] o_Addr_Data;
    SPI_Command  o_Command;

    nand_prog_seq #(
        .MIN_LOAD_BYTES (128),
        .MAX_POLLS      (TB_MAX_POLLS),
        .POLL_GAP       (TB_POLL_GAP),
        .STATUS_ADDR    (8'hC0)
    ) dut (
        .CLK1              (CLK1),
        .rst_n             (rst_n),
        .i_Start           (i_Start),
        .i_Col_Addr        (i_Col_Addr),
        .i_Page_Addr       (i_Page_Addr),
        .i_Fifo_Count      (i_Fifo_Count),
        .o_Busy            (o_Busy),
        .o_Done            (o_Done),
        .o_Reject          (o_Reject),
        .o_Fail            (o_Fail),
        .o_Timeout         (o_Timeout),
        .o_Status          (o_Status),
        .o_Command         (o_Command),
        .o_CM_DV           (o_CM_DV),
        .o_Addr_Data       (o_Addr_Data),
        .i_CM_Ready        (i_CM_Ready),
        .i_RX_Feature_Byte (i_RX_Feature_Byte),
        .i_RX_Feature_DV   (i_RX_Feature_DV)
    );

    always #5 CLK1 = ~CLK1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Expected values for the next sampled cycle
    logic        m_busy = 1'b0, m_done = 1'b0, m_reject = 1'b0;
    logic        m_fail = 1'b0, m_timeout = 1'b0;
    logic [7:0]  m_status = 8'h0;
    SPI_Command  m_cmd = WRITE_ENABLE;
    logic [23:0] m_addr = 24'h0;
    ent_t        exp_q[$];

    // Device responder state
    SPI_Command  cur_cmd = WRITE_ENABLE;
    int          lat = 0;
    int          hold_cnt = 0;
    bit          hold_after_wren = 1'b0;
    int          t_hold = -1;
    bit          nodv_next = 1'b0;
    logic [7:0]  script[$];
    int          polls = 0;
    int          gap_start = -1;
    logic        prev_dv = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic poll_complete();
        logic [7:0] s;
        polls++;
        if (nodv_next) begin
            s = 8'h01;
            nodv_next = 1'b0;
        end else begin
            s = (script.size() != 0) ? script.pop_front() : 8'h01;
            i_RX_Feature_DV   = 1'b1;
            i_RX_Feature_Byte = s;
            m_status          = s;
        end
        if (!s[ST_BUSY]) begin
            m_done = 1'b1;
            m_busy = 1'b0;
            m_fail = s[ST_PFAIL];
        end else if (polls == TB_MAX_POLLS) begin
            m_done    = 1'b1;
            m_busy    = 1'b0;
            m_timeout = 1'b1;
        end else begin
            gap_start = cyc;
        end
    endtask

    task automatic respond();
        i_RX_Feature_DV = 1'b0;
        if (!rst_n) begin
            i_CM_Ready = 1'b1;
            lat = 0;
            hold_cnt = 0;
        end else if (o_CM_DV) begin
            i_CM_Ready = 1'b0;
            lat = 3;
        end else if (lat > 0) begin
            lat--;
            if (lat == 0) begin
                i_CM_Ready = 1'b1;
                if (cur_cmd == WRITE_ENABLE && hold_after_wren) begin
                    hold_after_wren = 1'b0;
                    hold_cnt = 50;
                    t_hold = cyc;
                end
                if (cur_cmd == GET_FEATURE) poll_complete();
            end
        end else if (hold_cnt > 0) begin
            i_CM_Ready = 1'b0;
            hold_cnt--;
        end else begin
            i_CM_Ready = 1'b1;
        end
    endtask

    task automatic tick();
        ent_t e;
        @(negedge CLK1);
        cyc++;
        chk("busy", 32'(o_Busy), 32'(m_busy));
        chk("done", 32'(o_Done), 32'(m_done));
        chk("reject", 32'(o_Reject), 32'(m_reject));
        chk("fail", 32'(o_Fail), 32'(m_fail));
        chk("timeout", 32'(o_Timeout), 32'(m_timeout));
        chk("status", 32'(o_Status), 32'(m_status));
        if (o_CM_DV) begin
            chk("dv_width", 32'(prev_dv), 32'd0);
            chk("dv_when_ready", 32'(i_CM_Ready), 32'd1);
            chk("dv_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                m_cmd   = e.cmd;
                m_addr  = e.addr;
                cur_cmd = e.cmd;
                if (e.cmd == GET_FEATURE && polls > 0)
                    chk("poll_gap", 32'((cyc - gap_start) >= TB_POLL_GAP + 1 &&
                                        (cyc - gap_start) <= TB_POLL_GAP + 2), 32'd1);
                if (e.cmd == PROG_LOAD1 && t_hold >= 0) begin
                    chk("load_after_hold", 32'((cyc - t_hold) >= 51), 32'd1);
                    t_hold = -1;
                end
            end
        end
        chk("command", 32'(o_Command), 32'(m_cmd));
        chk("addr", 32'(o_Addr_Data), 32'(m_addr));
        m_done   = 1'b0;
        m_reject = 1'b0;
        prev_dv  = o_CM_DV;
        respond();
    endtask

    task automatic start_seq(input int cnt, input logic [12:0] col, input logic [15:0] page,
                             input int npolls);
        i_Fifo_Count = 12'(cnt);
        i_Col_Addr   = col;
        i_Page_Addr  = page;
        i_Start      = 1'b1;
        if (cnt >= 128) begin
            m_busy = 1'b1; m_fail = 1'b0; m_timeout = 1'b0; m_status = 8'h0;
            polls = 0; gap_start = -1;
            exp_q.push_back('{WRITE_ENABLE, 24'h000000});
            exp_q.push_back('{PROG_LOAD1, {11'h0, col}});
            exp_q.push_back('{PROG_EXEC, {8'h00, page}});
            for (int i = 0; i < npolls; i++) exp_q.push_back('{GET_FEATURE, 24'h00C000});
        end else begin
            m_reject = 1'b1;
        end
        tick();
        i_Start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit ended;
        ended = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (m_done) begin
                tick();
                ended = 1'b1;
                break;
            end
        end
        chk({nm, "_completed"}, 32'(ended), 32'd1);
        chk({nm, "_all_issued"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: three busy polls, then ready; a second start mid-sequence is ignored
        script = '{8'h01, 8'h01, 8'h01, 8'h00};
        start_seq(200, 13'h1ABC, 16'hBEEF, 4);
        repeat (10) tick();
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        wait_done("t1");
        chk("t1_polls", 32'(polls), 32'd4);
        chk("t1_flags", {23'h0, o_Fail, o_Timeout, o_Status}, 32'h0);
        repeat (5) tick();

        // 2: underfilled FIFO is refused, including one short of the threshold
        start_seq(100, 13'h0001, 16'h0001, 0);
        repeat (4) tick();
        start_seq(127, 13'h0001, 16'h0001, 0);
        repeat (4) tick();

        // 3: exact threshold accepted, program-fail status reported
        script = '{8'h01, 8'h08};
        start_seq(128, 13'h0000, 16'h1234, 2);
        wait_done("t3");
        chk("t3_fail", 32'(o_Fail), 32'd1);
        chk("t3_status", 32'(o_Status), 32'h08);
        repeat (3) tick();

        // 4: never ready; first poll completes without a feature byte
        script = '{8'h01, 8'h01, 8'h01, 8'h01};
        nodv_next = 1'b1;
        start_seq(300, 13'h1FFF, 16'hFFFF, TB_MAX_POLLS);
        wait_done("t4");
        chk("t4_timeout", 32'(o_Timeout), 32'd1);
        chk("t4_polls", 32'(polls), 32'd4);
        chk("t4_status", 32'(o_Status), 32'h01);
        repeat (3) tick();

        // 5: ready held low before the load issue
        script = '{8'h00};
        hold_after_wren = 1'b1;
        start_seq(4095, 13'h0055, 16'h00AA, 1);
        wait_done("t5");
        repeat (3) tick();

        // 6: reset while in the inter-poll gap, then a clean restart
        script = '{8'h01, 8'h01, 8'h01, 8'h01};
        start_seq(200, 13'h0100, 16'h0200, 4);
        for (int i = 0; i < 2000; i++) begin
            tick();
            if (gap_start >= 0 && cyc >= gap_start + 5) break;
        end
        chk("t6_in_gap", 32'(polls), 32'd1);
        rst_n = 1'b0;
        m_busy = 1'b0; m_done = 1'b0; m_reject = 1'b0;
        m_fail = 1'b0; m_timeout = 1'b0; m_status = 8'h0;
        m_cmd = WRITE_ENABLE; m_addr = 24'h0;
        exp_q.delete();
        script.delete();
        i_CM_Ready = 1'b1; lat = 0; hold_cnt = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        script = '{8'h01, 8'h01, 8'h01, 8'h00};
        start_seq(200, 13'h0ABC, 16'h4321, 4);
        wait_done("t6");
        chk("t6_no_timeout", 32'(o_Timeout), 32'd0);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
